// File: rtl/matrix_mac_engine.sv
// Signed fixed-point matrix multiplier Z = X*Y over external single-port RAMs.
// One MAC per cycle per element; running-adder address generation; scaled, ReLU'd, saturated writeback.
module matrix_mac_engine #(
   parameter int ADDR_WIDTH  = 16,
   parameter int DATA_WIDTH  = 16,
   parameter int ACC_WIDTH   = 40,
   parameter int FRAC_BITS   = 8,
   parameter int RAM_LATENCY = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  relu_en,
   input  logic [ADDR_WIDTH-1:0] x_rows,
   input  logic [ADDR_WIDTH-1:0] y_cols,
   input  logic [ADDR_WIDTH-1:0] inner_dim,
   input  logic [ADDR_WIDTH-1:0] x_base,
   input  logic [ADDR_WIDTH-1:0] y_base,
   input  logic [ADDR_WIDTH-1:0] z_base,
   output logic [ADDR_WIDTH-1:0] x_addr,
   output logic                  x_ren,
   input  logic [DATA_WIDTH-1:0] x_data,
   output logic [ADDR_WIDTH-1:0] y_addr,
   output logic                  y_ren,
   input  logic [DATA_WIDTH-1:0] y_data,
   output logic [ADDR_WIDTH-1:0] z_addr,
   output logic [DATA_WIDTH-1:0] z_data,
   output logic                  z_wen,
   output logic                  busy,
   output logic                  done,
   output logic                  sat_flag
);
   localparam int PW = 2 * DATA_WIDTH;
   localparam logic [ADDR_WIDTH-1:0] ONE = ADDR_WIDTH'(1);
   localparam logic signed [ACC_WIDTH-1:0] ZMAX =
      {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
   localparam logic signed [ACC_WIDTH-1:0] ZMIN = ~ZMAX;

   typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DRAIN, S_WRITE, S_FIN} state_t;
   state_t state, state_nxt;

   logic [ADDR_WIDTH-1:0] m_l, n_l, k_l, y_base_l;
   logic                  relu_l;
   logic [ADDR_WIDTH-1:0] i_cnt, j_cnt, k_cnt, d_cnt;
   logic [ADDR_WIDTH-1:0] x_row, x_addr_r, y_col, y_addr_r, z_addr_r;

   logic [RAM_LATENCY-1:0]       ren_pipe;
   logic signed [PW-1:0]         prod;
   logic                         prod_v;
   logic signed [ACC_WIDTH-1:0]  acc, shifted;
   logic [DATA_WIDTH-1:0]        z_val;
   logic                         sat_hit;

   logic dims_zero, last_k, last_drain, last_col, last_elem;
   assign dims_zero  = (x_rows == '0) || (y_cols == '0) || (inner_dim == '0);
   assign last_k     = (k_cnt == k_l - ONE);
   assign last_drain = (d_cnt == ADDR_WIDTH'(RAM_LATENCY));
   assign last_col   = (j_cnt == n_l - ONE);
   assign last_elem  = last_col && (i_cnt == m_l - ONE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (start) state_nxt = dims_zero ? S_FIN : S_FETCH;
         S_FETCH: if (last_k) state_nxt = S_DRAIN;
         S_DRAIN: if (last_drain) state_nxt = S_WRITE;
         S_WRITE: state_nxt = last_elem ? S_FIN : S_FETCH;
         S_FIN:   state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      busy   = (state == S_FETCH) || (state == S_DRAIN) || (state == S_WRITE);
      done   = (state == S_FIN);
      x_ren  = (state == S_FETCH);
      y_ren  = (state == S_FETCH);
      z_wen  = (state == S_WRITE);
      x_addr = x_addr_r;
      y_addr = y_addr_r;
      z_addr = z_addr_r;
      z_data = (state == S_WRITE) ? z_val : '0;
   end

   // Row/column bases are kept so each new element reloads its address instead of multiplying.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         m_l <= '0; n_l <= '0; k_l <= '0; y_base_l <= '0; relu_l <= 1'b0;
         i_cnt <= '0; j_cnt <= '0; k_cnt <= '0; d_cnt <= '0;
         x_row <= '0; x_addr_r <= '0; y_col <= '0; y_addr_r <= '0; z_addr_r <= '0;
         sat_flag <= 1'b0;
      end else begin
         case (state)
            S_IDLE: if (start) begin
               m_l <= x_rows; n_l <= y_cols; k_l <= inner_dim;
               y_base_l <= y_base; relu_l <= relu_en;
               i_cnt <= '0; j_cnt <= '0; k_cnt <= '0; d_cnt <= '0;
               x_row <= x_base; x_addr_r <= x_base;
               y_col <= y_base; y_addr_r <= y_base;
               z_addr_r <= z_base;
               sat_flag <= 1'b0;
            end
            S_FETCH: begin
               x_addr_r <= x_addr_r + ONE;
               y_addr_r <= y_addr_r + n_l;
               k_cnt    <= last_k ? '0 : k_cnt + ONE;
               d_cnt    <= '0;
            end
            S_DRAIN: d_cnt <= d_cnt + ONE;
            S_WRITE: begin
               z_addr_r <= z_addr_r + ONE;
               if (sat_hit) sat_flag <= 1'b1;
               if (last_col) begin
                  j_cnt    <= '0;
                  i_cnt    <= i_cnt + ONE;
                  x_row    <= x_row + k_l;
                  x_addr_r <= x_row + k_l;
                  y_col    <= y_base_l;
                  y_addr_r <= y_base_l;
               end else begin
                  j_cnt    <= j_cnt + ONE;
                  y_col    <= y_col + ONE;
                  y_addr_r <= y_col + ONE;
                  x_addr_r <= x_row;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ren_pipe <= '0;
         prod     <= '0;
         prod_v   <= 1'b0;
         acc      <= '0;
      end else begin
         ren_pipe <= RAM_LATENCY'({ren_pipe, x_ren});
         prod_v   <= ren_pipe[RAM_LATENCY-1];
         if (ren_pipe[RAM_LATENCY-1])
            prod <= PW'($signed(x_data)) * PW'($signed(y_data));
         if ((state == S_FETCH) && (k_cnt == '0)) acc <= '0;
         else if (prod_v)                       acc <= acc + ACC_WIDTH'(prod);
      end
   end

   always_comb begin
      shifted = acc >>> FRAC_BITS;
      if (relu_l && shifted[ACC_WIDTH-1]) shifted = '0;
      sat_hit = 1'b0;
      z_val   = shifted[DATA_WIDTH-1:0];
      if (shifted > ZMAX) begin
         sat_hit = 1'b1;
         z_val   = ZMAX[DATA_WIDTH-1:0];
      end else if (shifted < ZMIN) begin
         sat_hit = 1'b1;
         z_val   = ZMIN[DATA_WIDTH-1:0];
      end
   end
endmodule
